// File: rtl/sprite_sched_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | sprite_sched_pkg : shared state encodings and width helpers       |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
package sprite_sched_pkg;

    localparam logic [2:0] c_st_idle  = 3'd0;
    localparam logic [2:0] c_st_latch = 3'd1;
    localparam logic [2:0] c_st_scan  = 3'd2;
    localparam logic [2:0] c_st_wait  = 3'd3;
    localparam logic [2:0] c_st_done  = 3'd4;

    // Index width for n entries, never below 1 so buses stay legal.
    function automatic int idx_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sprite_slot_hit.sv
`default_nettype none
// +------------------------------------------------------------------+
// | sprite_slot_hit : per-slot horizontal hit and opacity test        |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module sprite_slot_hit
    import sprite_sched_pkg::*;
#(
    parameter int CORDW     = 10,
    parameter int SPR_WIDTH = 8
) (
    input  logic signed [CORDW-1:0]     sx,
    input  logic signed [CORDW-1:0]     x_i,
    input  logic        [SPR_WIDTH-1:0] buf_i,
    input  logic                        valid_i,
    output logic                        hit_i,
    output logic                        opaque_i
);

    localparam int                     COLW = idx_width(SPR_WIDTH);
    localparam logic signed [CORDW:0]  c_w  = (CORDW+1)'(SPR_WIDTH);

    logic signed [CORDW:0]  w_dx;
    logic [SPR_WIDTH-1:0]   w_rev;

    // One extra bit keeps the difference exact near the coordinate extremes.
    assign w_dx = {sx[CORDW-1], sx} - {x_i[CORDW-1], x_i};

    generate
        for (genvar g = 0; g < SPR_WIDTH; g++) begin : g_rev
            assign w_rev[g] = buf_i[SPR_WIDTH-1-g];
        end
    endgenerate

    assign hit_i    = valid_i && !w_dx[CORDW] && (w_dx < c_w);
    assign opaque_i = hit_i && w_rev[w_dx[COLW-1:0]];

endmodule
`default_nettype wire

// File: rtl/sprite_scheduler.sv
`default_nettype none
// +------------------------------------------------------------------+
// | sprite_scheduler : shared sprite-row ROM fetch and pixel priority |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module sprite_scheduler
    import sprite_sched_pkg::*;
#(
    parameter int CORDW      = 10,
    parameter int NUM_SPR    = 4,
    parameter int SPR_WIDTH  = 8,
    parameter int SPR_HEIGHT = 8,
    parameter int IMGW       = 2
) (
    input  logic                                      clk,
    input  logic                                      rst_n,
    input  logic                                      line_start,
    input  logic                                      frame,
    input  logic signed [CORDW-1:0]                   next_sy,
    input  logic signed [CORDW-1:0]                   sx,
    input  logic        [NUM_SPR-1:0]                 spr_en,
    input  logic        [NUM_SPR*CORDW-1:0]           spr_x,
    input  logic        [NUM_SPR*CORDW-1:0]           spr_y,
    input  logic        [NUM_SPR*IMGW-1:0]            spr_img,
    output logic                                      rom_en,
    output logic [IMGW+idx_width(SPR_HEIGHT)-1:0]     rom_addr,
    input  logic        [SPR_WIDTH-1:0]               rom_data,
    output logic                                      pix,
    output logic [idx_width(NUM_SPR)-1:0]             spr_id,
    output logic                                      drawing,
    output logic                                      collision,
    output logic                                      busy
);

    localparam int SLOTW = idx_width(NUM_SPR);
    localparam int ROWW  = idx_width(SPR_HEIGHT);
    localparam int ADDRW = IMGW + ROWW;
    localparam logic signed [CORDW:0] c_h    = (CORDW+1)'(SPR_HEIGHT);
    localparam logic [SLOTW-1:0]      c_last = SLOTW'(NUM_SPR-1);

    logic [2:0]                r_state;
    logic [SLOTW-1:0]          r_k;
    logic [NUM_SPR*CORDW-1:0]  r_x;
    logic [NUM_SPR*CORDW-1:0]  r_y;
    logic [NUM_SPR*IMGW-1:0]   r_img;
    logic [NUM_SPR-1:0]        r_en;
    logic [NUM_SPR-1:0]        r_valid;
    logic signed [CORDW-1:0]   r_sy;
    logic [SPR_WIDTH-1:0]      r_buf [NUM_SPR];
    logic [ADDRW-1:0]          r_addr;

    logic signed [CORDW-1:0]   w_yk;
    logic signed [CORDW:0]     w_row;
    logic [IMGW-1:0]           w_imgk;
    logic                      w_active;
    logic                      w_fetch;
    logic                      w_last;
    logic                      w_busy;
    logic [ADDRW-1:0]          w_addr;

    assign w_yk     = r_y[int'(r_k)*CORDW +: CORDW];
    assign w_imgk   = r_img[int'(r_k)*IMGW +: IMGW];
    assign w_row    = {r_sy[CORDW-1], r_sy} - {w_yk[CORDW-1], w_yk};
    assign w_active = r_en[r_k] && !w_row[CORDW] && (w_row < c_h);
    assign w_fetch  = (r_state == c_st_scan) && w_active;
    assign w_last   = (r_k == c_last);
    assign w_addr   = {w_imgk, w_row[ROWW-1:0]};
    assign w_busy   = (r_state == c_st_latch) || (r_state == c_st_scan) ||
                      (r_state == c_st_wait);

    // The ROM samples the address in the SCAN cycle itself; r_addr only
    // keeps the bus steady between fetches.
    assign rom_en   = w_fetch;
    assign rom_addr = w_fetch ? w_addr : r_addr;
    assign busy     = w_busy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_st_idle;
            r_k     <= '0;
            r_x     <= '0;
            r_y     <= '0;
            r_img   <= '0;
            r_en    <= '0;
            r_valid <= '0;
            r_sy    <= '0;
            r_addr  <= '0;
            for (int i = 0; i < NUM_SPR; i++) r_buf[i] <= '0;
        end else if (line_start) begin
            r_state <= c_st_latch;
            r_valid <= '0;
        end else begin
            case (r_state)
                c_st_latch: begin
                    r_x     <= spr_x;
                    r_y     <= spr_y;
                    r_img   <= spr_img;
                    r_en    <= spr_en;
                    r_sy    <= next_sy;
                    r_k     <= '0;
                    r_state <= c_st_scan;
                end
                c_st_scan: begin
                    if (w_active) begin
                        r_addr  <= w_addr;
                        r_state <= c_st_wait;
                    end else if (w_last) begin
                        r_state <= c_st_done;
                    end else begin
                        r_k <= r_k + SLOTW'(1);
                    end
                end
                c_st_wait: begin
                    r_buf[r_k]   <= rom_data;
                    r_valid[r_k] <= 1'b1;
                    if (w_last) begin
                        r_state <= c_st_done;
                    end else begin
                        r_k     <= r_k + SLOTW'(1);
                        r_state <= c_st_scan;
                    end
                end
                c_st_done: r_state <= c_st_idle;
                default:   r_state <= c_st_idle;
            endcase
        end
    end

    logic [NUM_SPR-1:0] w_hit;
    logic [NUM_SPR-1:0] w_opq;

    generate
        for (genvar i = 0; i < NUM_SPR; i++) begin : g_slot
            sprite_slot_hit #(
                .CORDW     (CORDW),
                .SPR_WIDTH (SPR_WIDTH)
            ) u_hit (
                .sx       (sx),
                .x_i      (r_x[i*CORDW +: CORDW]),
                .buf_i    (r_buf[i]),
                .valid_i  (r_valid[i]),
                .hit_i    (w_hit[i]),
                .opaque_i (w_opq[i])
            );
        end
    endgenerate

    logic [SLOTW-1:0] w_hit_id;
    logic [SLOTW-1:0] w_opq_id;
    logic             w_seen;
    logic             w_multi;

    // Descending scan so the lowest index is the last (winning) write.
    always_comb begin
        w_hit_id = '0;
        w_opq_id = '0;
        w_seen   = 1'b0;
        w_multi  = 1'b0;
        for (int i = NUM_SPR - 1; i >= 0; i--) begin
            if (w_hit[i]) w_hit_id = SLOTW'(i);
            if (w_opq[i]) w_opq_id = SLOTW'(i);
        end
        for (int i = 0; i < NUM_SPR; i++) begin
            if (w_opq[i]) begin
                if (w_seen) w_multi = 1'b1;
                w_seen = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pix       <= 1'b0;
            drawing   <= 1'b0;
            spr_id    <= '0;
            collision <= 1'b0;
        end else begin
            pix     <= (|w_opq) && !w_busy;
            drawing <= (|w_hit) && !w_busy;
            spr_id  <= (|w_opq) ? w_opq_id : w_hit_id;
            if (w_multi)
                collision <= 1'b1;
            else if (frame)
                collision <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sprite_scheduler.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_sprite_scheduler : table-driven bench with expectation queue   |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module tb_sprite_scheduler;

    localparam int CORDW      = 10;
    localparam int NUM_SPR    = 4;
    localparam int SPR_WIDTH  = 8;
    localparam int SPR_HEIGHT = 8;
    localparam int IMGW       = 2;
    localparam int SLOTW      = 2;
    localparam int ADDRW      = 5;
    localparam int MAXFETCH   = 2 * NUM_SPR + 1;

    logic                       clk;
    logic                       rst_n;
    logic                       line_start;
    logic                       frame;
    logic signed [CORDW-1:0]    next_sy;
    logic signed [CORDW-1:0]    sx;
    logic [NUM_SPR-1:0]         spr_en;
    logic [NUM_SPR*CORDW-1:0]   spr_x;
    logic [NUM_SPR*CORDW-1:0]   spr_y;
    logic [NUM_SPR*IMGW-1:0]    spr_img;
    logic                       rom_en;
    logic [ADDRW-1:0]           rom_addr;
    logic [SPR_WIDTH-1:0]       rom_data = '0;
    logic                       pix;
    logic [SLOTW-1:0]           spr_id;
    logic                       drawing;
    logic                       collision;
    logic                       busy;

    sprite_scheduler #(
        .CORDW      (CORDW),
        .NUM_SPR    (NUM_SPR),
        .SPR_WIDTH  (SPR_WIDTH),
        .SPR_HEIGHT (SPR_HEIGHT),
        .IMGW       (IMGW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .line_start (line_start),
        .frame      (frame),
        .next_sy    (next_sy),
        .sx         (sx),
        .spr_en     (spr_en),
        .spr_x      (spr_x),
        .spr_y      (spr_y),
        .spr_img    (spr_img),
        .rom_en     (rom_en),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data),
        .pix        (pix),
        .spr_id     (spr_id),
        .drawing    (drawing),
        .collision  (collision),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous ROM: data valid the cycle after rom_en.
    logic [SPR_WIDTH-1:0] rom_mem [32];
    always @(posedge clk) if (rom_en) rom_data <= rom_mem[rom_addr];

    typedef struct {
        int grp;
        int sx;
        bit frame;
        bit pix;
        bit drawing;
        int id;
        bit coll;
    } vec_t;

    vec_t tbl [48];
    int   n_vec;
    vec_t exp_q [$];
    int   n_tests;
    int   n_fail;

    function automatic void add(input int g, input int s, input bit f, input bit p,
                                input bit d, input int id, input bit c);
        tbl[n_vec] = '{g, s, f, p, d, id, c};
        n_vec++;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_slot(input int i, input bit en, input int x, input int y, input int img);
        spr_en[i]                 = en;
        spr_x[i*CORDW +: CORDW]   = CORDW'(x);
        spr_y[i*CORDW +: CORDW]   = CORDW'(y);
        spr_img[i*IMGW +: IMGW]   = IMGW'(img);
    endtask

    task automatic run_group(input int g);
        vec_t e;
        for (int i = 0; i < n_vec; i++) begin
            if (tbl[i].grp == g) begin
                sx    = CORDW'(tbl[i].sx);
                frame = tbl[i].frame;
                exp_q.push_back(tbl[i]);
                tick();
                frame = 1'b0;
                e = exp_q.pop_front();
                check($sformatf("g%0d sx=%0d pix", g, e.sx), int'(pix), int'(e.pix));
                check($sformatf("g%0d sx=%0d drawing", g, e.sx), int'(drawing), int'(e.drawing));
                check($sformatf("g%0d sx=%0d spr_id", g, e.sx), int'(spr_id), e.id);
                check($sformatf("g%0d sx=%0d collision", g, e.sx), int'(collision), int'(e.coll));
            end
        end
    endtask

    // Pulse line_start and follow the fetch to completion.
    task automatic fetch(input string name, input int exp_pulses, input int exp_cycles,
                         input int exp_addr);
        int cycles;
        int pulses;
        int addr;
        line_start = 1'b1;
        tick();
        line_start = 1'b0;
        cycles = 0;
        pulses = 0;
        addr   = -1;
        while (busy && cycles < MAXFETCH + 4) begin
            if (rom_en) begin
                pulses++;
                addr = int'(rom_addr);
            end
            tick();
            cycles++;
        end
        check({name, " busy released"}, int'(busy), 0);
        check({name, " fetch within bound"}, int'(cycles <= MAXFETCH), 1);
        check({name, " fetch cycles"}, cycles, exp_cycles);
        check({name, " rom_en pulses"}, pulses, exp_pulses);
        check({name, " last rom_addr"}, addr, exp_addr);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int pulses;
        int seen;

        n_tests = 0; n_fail = 0; n_vec = 0;
        rst_n = 1'b0; line_start = 1'b0; frame = 1'b0;
        next_sy = '0; sx = '0; spr_en = '0; spr_x = '0; spr_y = '0; spr_img = '0;
        for (int i = 0; i < 32; i++) rom_mem[i] = 8'h5A;
        rom_mem[11] = 8'h81;   // img 1, row 3
        rom_mem[16] = 8'hFF;   // img 2, row 0
        rom_mem[24] = 8'hFF;   // img 3, row 0
        rom_mem[5]  = 8'h00;   // img 0, row 5: fully transparent

        //  grp  sx  frm pix drw id coll
        add(0,   9, 0, 0, 0, 0, 0);
        add(0,  10, 0, 1, 1, 0, 0);
        add(0,  11, 0, 0, 1, 0, 0);
        add(0,  16, 0, 0, 1, 0, 0);
        add(0,  17, 0, 1, 1, 0, 0);
        add(0,  18, 0, 0, 0, 0, 0);
        add(1,  39, 0, 0, 0, 0, 0);
        add(1,  40, 0, 1, 1, 0, 1);
        add(1,  44, 0, 1, 1, 0, 1);
        add(1,  47, 0, 1, 1, 0, 1);
        add(1,  48, 1, 0, 0, 0, 0);
        add(1,  41, 1, 1, 1, 0, 1);
        add(1, 100, 0, 0, 0, 0, 1);
        add(1, 100, 1, 0, 0, 0, 0);
        add(2,   0, 0, 1, 1, 1, 0);
        add(2,   2, 0, 1, 1, 1, 0);
        add(2,   4, 0, 1, 1, 1, 0);
        add(2,   5, 0, 0, 1, 3, 0);
        add(2,   9, 0, 0, 1, 3, 0);
        add(2,  10, 0, 0, 0, 0, 0);
        add(3, 100, 0, 1, 1, 3, 0);
        add(3, 101, 0, 0, 1, 3, 0);
        add(3, 107, 0, 1, 1, 3, 0);
        add(3, 108, 0, 0, 0, 0, 0);
        add(4, 200, 0, 0, 0, 0, 0);
        add(4, 250, 0, 0, 0, 0, 0);
        add(4, 300, 0, 1, 1, 1, 0);
        add(4, 301, 0, 0, 1, 1, 0);
        add(6,   0, 0, 1, 1, 0, 0);
        add(6,   7, 0, 1, 1, 0, 0);
        add(6,  20, 0, 1, 1, 1, 0);
        add(6,  21, 0, 0, 1, 1, 0);
        add(5,   0, 0, 0, 0, 0, 0);
        add(5,  20, 0, 0, 0, 0, 0);

        tick(); tick();
        check("reset pix", int'(pix), 0);
        check("reset drawing", int'(drawing), 0);
        check("reset collision", int'(collision), 0);
        check("reset busy", int'(busy), 0);
        check("reset rom_en", int'(rom_en), 0);
        check("reset rom_addr", int'(rom_addr), 0);
        check("reset spr_id", int'(spr_id), 0);
        rst_n = 1'b1;
        tick();

        // Single slot, row 3 of image 1.
        set_slot(0, 1, 10, 20, 1);
        next_sy = 10'sd23;
        fetch("A", 1, 6, 11);
        run_group(0);

        // Two overlapping opaque slots.
        spr_en = '0;
        set_slot(0, 1, 40, 100, 2);
        set_slot(2, 1, 40, 100, 2);
        next_sy = 10'sd100;
        fetch("B", 2, 7, 16);
        run_group(1);

        // Negative-x clip plus a transparent slot behind it.
        spr_en = '0;
        set_slot(0, 1, 0, 60, 0);
        set_slot(1, 1, -3, 50, 3);
        set_slot(2, 0, 0, 50, 3);
        set_slot(3, 1, 2, 45, 0);
        next_sy = 10'sd50;
        fetch("C", 2, 7, 5);
        run_group(2);

        // Only slot 3 in range; slots 0 and 1 sit one row outside either edge.
        set_slot(0, 1, 100, 15, 1);
        set_slot(1, 1, 100, 24, 1);
        set_slot(2, 1, 100, 0, 1);
        set_slot(3, 1, 100, 20, 1);
        next_sy = 10'sd23;
        fetch("D", 1, 6, 11);
        run_group(3);

        // Restart while slot 1 is in WAIT; slot 0 was already valid.
        spr_en = '0;
        set_slot(0, 1, 200, 20, 1);
        set_slot(1, 1, 250, 20, 1);
        next_sy = 10'sd23;
        line_start = 1'b1;
        tick();
        line_start = 1'b0;
        pulses = 0;
        for (int c = 0; c < 20 && pulses < 2; c++) begin
            if (rom_en) pulses++;
            if (pulses < 2) tick();
        end
        check("restart reached slot 1 fetch", pulses, 2);
        tick();
        set_slot(0, 0, 200, 20, 1);
        set_slot(1, 1, 300, 20, 1);
        fetch("R", 1, 6, 11);
        run_group(4);

        // All four slots active: worst-case fetch length.
        for (int i = 0; i < NUM_SPR; i++) set_slot(i, 1, i * 20, 20, 1);
        fetch("W", 4, MAXFETCH, 11);
        run_group(6);

        // Reset with valid buffers, then a fresh line aborted by reset mid-fetch.
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        run_group(5);
        line_start = 1'b1;
        tick();
        line_start = 1'b0;
        tick();
        check("mid-fetch rom_en before reset", int'(rom_en), 1);
        rst_n = 1'b0;
        #1;
        check("async reset rom_en", int'(rom_en), 0);
        check("async reset busy", int'(busy), 0);
        check("async reset pix", int'(pix), 0);
        tick();
        rst_n = 1'b1;
        seen = 0;
        for (int c = 0; c < MAXFETCH + 2; c++) begin
            if (rom_en || busy) seen++;
            tick();
        end
        check("no fetch resumes after reset", seen, 0);
        run_group(5);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sprite_scheduler.md
Name: sprite_scheduler

Overview:
- Shares one synchronous sprite-row ROM among NUM_SPR sprite slots (duck, obstacles, etc.).
- During horizontal blanking, fetches one bitmap row per slot that is active on the upcoming line into per-slot row buffers.
- During active video, resolves per-pixel priority (lowest slot index wins) and flags sprite-sprite collisions.
- Sits between game logic (positions, images) and the colour/compositing stage.

Parameters:
- CORDW, 10, signed coordinate width.
- NUM_SPR, 4, number of sprite slots (2..8).
- SPR_WIDTH, 8, sprite width in pixels; ROM word width.
- SPR_HEIGHT, 8, sprite height in rows.
- IMGW, 2, image-select width; the ROM holds 2**IMGW images.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous, active-low reset.
- line_start  in  1  1-cycle pulse at start of horizontal blanking preceding line next_sy.
- frame  in  1  1-cycle pulse at start of frame; clears collision.
- next_sy  in  CORDW  signed y of the line being prepared.
- sx  in  CORDW  signed current screen x; valid during active video.
- spr_en  in  NUM_SPR  per-slot enable.
- spr_x  in  NUM_SPR*CORDW  packed signed x per slot; slot i at [i*CORDW +: CORDW].
- spr_y  in  NUM_SPR*CORDW  packed signed y per slot.
- spr_img  in  NUM_SPR*IMGW  packed image index per slot.
- rom_en  out  1  ROM read strobe.
- rom_addr  out  IMGW+clog2(SPR_HEIGHT)  address = {img, row}.
- rom_data  in  SPR_WIDTH  row data, valid 1 cycle after rom_en. MSB is the leftmost pixel.
- pix  out  1  opaque pixel present.
- spr_id  out  clog2(NUM_SPR)  winning slot index.
- drawing  out  1  some slot covers sx (opaque or not).
- collision  out  1  sticky: two or more opaque pixels coincided this frame.
- busy  out  1  fetch sequence in progress.

Behaviour:
- Reset (rst_n low, async): all outputs 0, state IDLE, all row buffers invalid, registered slot positions 0.
- States: IDLE, LATCH, SCAN, WAIT, DONE.
- line_start in any state → LATCH next cycle. All valid bits are cleared. This aborts any fetch in progress (restart, not resume). line_start has priority over all other transitions.
- LATCH: register spr_x, spr_y, spr_img, spr_en, next_sy; slot counter k=0; busy=1 → SCAN.
- SCAN: row = next_sy - y_k, computed at CORDW+1 bits signed.
  - Slot active iff en_k and 0 ≤ row < SPR_HEIGHT.
  - If active: rom_en=1, rom_addr={img_k, row[clog2(SPR_HEIGHT)-1:0]} → WAIT.
  - Else if k==NUM_SPR-1 → DONE; else k++ and stay in SCAN.
- WAIT: buf_k ← rom_data, valid_k ← 1. If k==NUM_SPR-1 → DONE, else k++ → SCAN.
- Worst-case fetch time is 2*NUM_SPR+1 cycles after line_start. The system guarantees line_start precedes sx=0 by at least 2*NUM_SPR+3 cycles.
- DONE: busy=0 → IDLE. Buffers hold until the next line_start.
- rom_en is high only in the SCAN cycle of an active slot; rom_addr holds its last value otherwise.
- Per-slot hit: valid_i and 0 ≤ (sx - x_i) < SPR_WIDTH, computed at CORDW+1 bits. Opaque_i = hit_i and buf_i[SPR_WIDTH-1-(sx-x_i)].
- Sprites partially off-screen (negative x, or x+W > H_RES) clip naturally; there is no wrap-around.
- Output latency is 1 cycle: pix, spr_id and drawing registered from the sx presented on the previous cycle.
  - pix = OR of opaque.
  - spr_id = lowest i with opaque_i; if none, lowest i with hit_i; else 0.
  - drawing = OR of hit.
- Collision: set when ≥2 opaque_i in the same cycle. Cleared by frame; if frame and a coincidence occur in the same cycle, set wins.
- Output masking: pix/drawing are 0 while busy. A stale buffer never drives output after line_start because valid bits are cleared.

Decomposition:
- Package sprite_sched_pkg: state localparams (IDLE=0, LATCH=1, SCAN=2, WAIT=3, DONE=4), width helpers (SLOTW=clog2(NUM_SPR), ROWW=clog2(SPR_HEIGHT)).
- Sub-module sprite_slot_hit, instanced NUM_SPR times:
  - inputs: sx, x_i, buf_i, valid_i.
  - outputs: hit_i, opaque_i. Purely combinational.
- The priority encoder, FSM and collision logic stay in sprite_scheduler.

Test Plan:
- Reset mid-fetch: assert rst_n=0 two cycles after line_start → rom_en=0, busy=0, pix=0 immediately. No buffer is valid after release until the next line_start.
- Slot 0 at (10,20), img 1, ROM[{1,3}]=8'b1000_0001; next_sy=23 → rom_addr=0x0B. At sx=10 and sx=17, pix=1 one cycle later; sx=11..16 → pix=0, drawing=1; sx=18 → drawing=0.
- Slots 0 and 2 both at x=40 with full-row data 0xFF → spr_id=0, pix=1, collision=1 from sx=40 (+1 cycle). frame pulse with no overlap clears collision.
- Sparse activity: only slot 3 active (next_sy in range), slots 0-2 out of range → exactly one rom_en pulse; busy falls 2*NUM_SPR+1 cycles after line_start or earlier.
- Negative x clip: slot 1 at x=-3, row 0xFF → pix=1 for sx=0..4 only.
- Restart: second line_start arriving while in WAIT → valid cleared, fetch restarts from k=0 with the newly latched positions.
